l2_cache_ctrl_nway: RTL and testbench
=====================================

Name: l2_cache_ctrl_nway

Overview:
Parametrised control FSM for the L2 cache. It sits between the L1-facing request port and the DRAM port, and drives the tag/data datapath of a WAYS-way set-associative, write-back, write-allocate array. Line transfers to and from DRAM are bursts of BEATS beats. Compared with the previous single-beat, direct-mapped controller, it adds:
- victim-way selection, with invalid ways preferred over LRU;
- a burst beat counter;
- saturating hit/miss/writeback statistics counters.

Parameters:
WAYS, 2, associativity; power of two, 1..8.
BEATS, 4, DRAM beats per cache line; power of two, 1..16.
CNT_W, 16, width of each statistics counter.
Derived: WAY_W = max(1, clog2(WAYS)); BEAT_W = max(1, clog2(BEATS)).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_read  input  1  L1 read request, held until mem_resp.
mem_write  input  1  L1 write request, held until mem_resp.
mem_resp  output  1  one-cycle completion pulse to L1.
pmem_resp  input  1  DRAM accepted or returned one beat.
pmem_read  output  1  DRAM burst read in progress.
pmem_write  output  1  DRAM burst write in progress.
pmem_beat  output  BEAT_W  current beat index within the burst.
hit_vec  input  WAYS  per-way tag match AND valid, for the current set.
valid_vec  input  WAYS  per-way valid bits, current set.
dirty_vec  input  WAYS  per-way dirty bits, current set.
lru_way  input  WAY_W  LRU way of the current set.
way_sel  output  WAY_W  way addressed by the datapath this cycle.
lru_set  output  1  mark way_sel most-recently-used.
tag_load  output  1  write the new tag into way_sel.
valid_set  output  1  set valid on way_sel.
dirty_set  output  1  set dirty on way_sel.
dirty_clr  output  1  clear dirty on way_sel.
data_write  output  1  write the data array at way_sel (beat pmem_beat when filling).
load_mux_sel  output  1  0: data from DRAM; 1: data from L1.
addr_sel  output  1  0: request address; 1: victim tag address for writeback.
hit_cnt, miss_cnt, wb_cnt  output  CNT_W each  saturating statistics.

Behaviour:
- Reset (async, rst_n=0):
  - state=COMPARE, victim_way=0, beat=0, all counters=0.
  - All 1-bit outputs 0; way_sel=0; pmem_beat=0.
  - Reset mid-burst abandons the burst immediately; the array is left partially filled but is not marked valid.
- Request: req = mem_read | mem_write. If both are high, it is treated as a write. All outputs are combinational from state and inputs; registers update on clk.
- COMPARE:
  - No req: all outputs 0.
  - req and |hit_vec:
    - way_sel = lowest set index in hit_vec; mem_resp=1; lru_set=1; hit_cnt++.
    - If write, also data_write=1, dirty_set=1, load_mux_sel=1.
    - Single-cycle hit latency.
  - req and no hit: this is a miss; miss_cnt++.
    - Victim = lowest-index way with valid_vec=0. If none, victim = lru_way. Latch it into victim_way.
    - Next state = WRITEBACK if the victim is valid and dirty (wb_cnt++), otherwise ALLOCATE. beat<=0.
  - One miss is counted once, not again when the refill is re-compared.
- WRITEBACK:
  - Outputs: pmem_write=1, addr_sel=1, way_sel=victim_way, pmem_beat=beat.
  - Each pmem_resp: beat++.
  - On pmem_resp with beat==BEATS-1: beat<=0, next state ALLOCATE, dirty_clr=1 that cycle.
- ALLOCATE:
  - Outputs: pmem_read=1, addr_sel=0, way_sel=victim_way, pmem_beat=beat, load_mux_sel=0.
  - Each pmem_resp: data_write=1, beat++.
  - On pmem_resp with beat==BEATS-1: tag_load=1, valid_set=1, dirty_clr=1; beat<=0; next state COMPARE.
  - The request is then re-evaluated and hits.
- No abort: if req drops during WRITEBACK or ALLOCATE, the burst still completes, and COMPARE then idles with no mem_resp.
- BEATS=1: every burst completes on the first pmem_resp; pmem_beat is constantly 0.
- Counters:
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - In a cycle with pmem_resp=0, pmem_read, pmem_write and way_sel hold steady.
- Invalid state encoding: return to COMPARE on the next clk.
- Miss-to-resp latency: 1 + (dirty ? BEATS DRAM beats : 0) + BEATS DRAM beats + 1 cycles, with pmem_resp-limited beats.

Test Plan:
- Reset mid-ALLOCATE (beat=2) with rst_n=0 pulse -> pmem_read=0 immediately; state COMPARE; counters 0; valid_set never pulsed.
- WAYS=2, BEATS=4. Read hit: hit_vec=2'b10 -> same cycle mem_resp=1, way_sel=1, lru_set=1, data_write=0; hit_cnt=1.
- Write hit: hit_vec=2'b01 -> mem_resp, data_write, dirty_set, load_mux_sel all 1 for one cycle with way_sel=0.
- Read miss, valid_vec=2'b01, lru_way=0 -> victim way 1 (invalid preferred). Then ALLOCATE: 4 pmem_resp beats with pmem_beat 0,1,2,3 and data_write on each. Final beat: tag_load, valid_set and dirty_clr. Then a hit cycle with mem_resp=1. Expect miss_cnt=1, wb_cnt=0.
- Write miss, valid_vec=2'b11, dirty_vec=2'b10, lru_way=1 -> WRITEBACK on way 1 with addr_sel=1 for 4 beats. pmem_resp held low 3 cycles between beats: outputs stable. Then ALLOCATE 4 beats, then write-hit completion. Expect wb_cnt=1.
- CNT_W=4: 20 consecutive read hits -> hit_cnt saturates at 15. A miss with req dropped after 1 fill beat -> fill completes, no mem_resp.

Source files
------------

// File: rtl/l2_cache_ctrl_nway.sv
// L2 cache control FSM: N-way set-associative, write-back, write-allocate,
// with burst DRAM transfers and saturating hit/miss/writeback statistics.
module l2_cache_ctrl_nway #(
    parameter  int WAYS   = 2,
    parameter  int BEATS  = 4,
    parameter  int CNT_W  = 16,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [BEAT_W-1:0] pmem_beat,
    input  logic [WAYS-1:0]   hit_vec,
    input  logic [WAYS-1:0]   valid_vec,
    input  logic [WAYS-1:0]   dirty_vec,
    input  logic [WAY_W-1:0]  lru_way,
    output logic [WAY_W-1:0]  way_sel,
    output logic              lru_set,
    output logic              tag_load,
    output logic              valid_set,
    output logic              dirty_set,
    output logic              dirty_clr,
    output logic              data_write,
    output logic              load_mux_sel,
    output logic              addr_sel,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

    logic               req;
    logic               any_hit;
    logic               any_inv;
    logic               last_beat;
    logic               victim_dirty;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   miss_way;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req       = mem_read | mem_write;
    assign any_hit   = |hit_vec;
    assign any_inv   = ~&valid_vec;
    assign last_beat = (beat_q == LAST_BEAT);
    assign miss_way  = any_inv ? inv_way : lru_way;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        hit_way      = '0;
        inv_way      = '0;
        victim_dirty = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i])    hit_way = WAY_W'(i);
            if (!valid_vec[i]) inv_way = WAY_W'(i);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == miss_way)
                victim_dirty = valid_vec[i] & dirty_vec[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        beat_d       = beat_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wb_cnt_d     = wb_cnt_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_beat    = '0;
        way_sel      = '0;
        lru_set      = 1'b0;
        tag_load     = 1'b0;
        valid_set    = 1'b0;
        dirty_set    = 1'b0;
        dirty_clr    = 1'b0;
        data_write   = 1'b0;
        load_mux_sel = 1'b0;
        addr_sel     = 1'b0;
        unique case (state_q)
            S_COMPARE: begin
                if (req && any_hit) begin
                    way_sel   = hit_way;
                    mem_resp  = 1'b1;
                    lru_set   = 1'b1;
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    if (mem_write) begin
                        data_write   = 1'b1;
                        dirty_set    = 1'b1;
                        load_mux_sel = 1'b1;
                    end
                end else if (req) begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    victim_d   = miss_way;
                    beat_d     = '0;
                    if (victim_dirty) begin
                        state_d  = S_WRITEBACK;
                        wb_cnt_d = sat_inc(wb_cnt_q);
                    end else begin
                        state_d  = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = victim_q;
                pmem_beat  = beat_q;
                if (pmem_resp) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        beat_d    = '0;
                        dirty_clr = 1'b1;
                        state_d   = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                pmem_beat = beat_q;
                if (pmem_resp) begin
                    data_write = 1'b1;
                    beat_d     = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        tag_load  = 1'b1;
                        valid_set = 1'b1;
                        dirty_clr = 1'b1;
                        beat_d    = '0;
                        state_d   = S_COMPARE;
                    end
                end
            end
            default: begin
                state_d = S_COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_COMPARE;
            victim_q   <= '0;
            beat_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            beat_q     <= beat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Directed bench for l2_cache_ctrl_nway (WAYS=2, BEATS=4, CNT_W=4).
// The bench plays the tag/data datapath by driving hit/valid/dirty/lru.
module tb_l2_cache_ctrl_nway;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic [1:0] pmem_beat;
    logic [1:0] hit_vec;
    logic [1:0] valid_vec;
    logic [1:0] dirty_vec;
    logic [0:0] lru_way;
    logic [0:0] way_sel;
    logic       lru_set;
    logic       tag_load;
    logic       valid_set;
    logic       dirty_set;
    logic       dirty_clr;
    logic       data_write;
    logic       load_mux_sel;
    logic       addr_sel;
    logic [3:0] hit_cnt;
    logic [3:0] miss_cnt;
    logic [3:0] wb_cnt;

    int n_assert;
    int n_fail;

    l2_cache_ctrl_nway #(
        .WAYS  (2),
        .BEATS (4),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .pmem_resp    (pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_beat    (pmem_beat),
        .hit_vec      (hit_vec),
        .valid_vec    (valid_vec),
        .dirty_vec    (dirty_vec),
        .lru_way      (lru_way),
        .way_sel      (way_sel),
        .lru_set      (lru_set),
        .tag_load     (tag_load),
        .valid_set    (valid_set),
        .dirty_set    (dirty_set),
        .dirty_clr    (dirty_clr),
        .data_write   (data_write),
        .load_mux_sel (load_mux_sel),
        .addr_sel     (addr_sel),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_resp"}, mem_resp, 0);
        chk({tag, "_pr"}, pmem_read, 0);
        chk({tag, "_pw"}, pmem_write, 0);
        chk({tag, "_dw"}, data_write, 0);
        chk({tag, "_vs"}, valid_set, 0);
    endtask

    // Four fill beats back to back; final beat installs the line.
    task automatic fill(input logic [0:0] way);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            pmem_resp = 1'b1;
            #1;
            chk("fill_pr", pmem_read, 1);
            chk("fill_way", way_sel, way);
            chk("fill_beat", pmem_beat, b);
            chk("fill_dw", data_write, 1);
            chk("fill_mux", load_mux_sel, 0);
            chk("fill_addr", addr_sel, 0);
            chk("fill_tag", tag_load, b == 3);
            chk("fill_vs", valid_set, b == 3);
            chk("fill_dc", dirty_clr, b == 3);
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        hit_vec   = 2'b00;
        valid_vec = 2'b00;
        dirty_vec = 2'b00;
        lru_way   = 1'b0;
        #3;
        chk_idle("rst");
        chk("rst_way", way_sel, 0);
        chk("rst_beat", pmem_beat, 0);
        chk("rst_hcnt", hit_cnt, 0);
        chk("rst_mcnt", miss_cnt, 0);
        chk("rst_wcnt", wb_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read hit in way 1
        @(negedge clk);
        mem_read  = 1'b1;
        hit_vec   = 2'b10;
        valid_vec = 2'b11;
        #1;
        chk("rh_resp", mem_resp, 1);
        chk("rh_way", way_sel, 1);
        chk("rh_lru", lru_set, 1);
        chk("rh_dw", data_write, 0);
        @(negedge clk);
        mem_read = 1'b0;
        hit_vec  = 2'b00;
        #1;
        chk("rh_cnt", hit_cnt, 1);
        chk("rh_idle", mem_resp, 0);

        // Write hit in way 0
        @(negedge clk);
        mem_write = 1'b1;
        hit_vec   = 2'b01;
        #1;
        chk("wh_resp", mem_resp, 1);
        chk("wh_dw", data_write, 1);
        chk("wh_ds", dirty_set, 1);
        chk("wh_mux", load_mux_sel, 1);
        chk("wh_way", way_sel, 0);
        @(negedge clk);
        mem_write = 1'b0;
        hit_vec   = 2'b00;
        #1;
        chk("wh_cnt", hit_cnt, 2);
        chk("wh_idle", data_write, 0);

        // Read miss, invalid way 1 preferred over LRU way 0
        @(negedge clk);
        mem_read  = 1'b1;
        valid_vec = 2'b01;
        dirty_vec = 2'b00;
        lru_way   = 1'b0;
        #1;
        chk("rm_resp", mem_resp, 0);
        chk("rm_pr0", pmem_read, 0);
        @(negedge clk);
        #1;
        chk("rm_pr", pmem_read, 1);
        chk("rm_pw", pmem_write, 0);
        chk("rm_way", way_sel, 1);
        chk("rm_beat", pmem_beat, 0);
        chk("rm_dw", data_write, 0);
        chk("rm_mcnt", miss_cnt, 1);
        fill(1'b1);
        @(negedge clk);
        pmem_resp = 1'b0;
        hit_vec   = 2'b10;
        valid_vec = 2'b11;
        #1;
        chk("rm_hit", mem_resp, 1);
        chk("rm_hway", way_sel, 1);
        chk("rm_hpr", pmem_read, 0);
        @(negedge clk);
        mem_read = 1'b0;
        hit_vec  = 2'b00;
        #1;
        chk("rm_mcnt2", miss_cnt, 1);
        chk("rm_wcnt", wb_cnt, 0);
        chk("rm_hcnt", hit_cnt, 3);

        // Write miss, dirty LRU way 1 needs writeback
        @(negedge clk);
        mem_write = 1'b1;
        dirty_vec = 2'b10;
        lru_way   = 1'b1;
        #1;
        chk("wm_resp", mem_resp, 0);
        @(negedge clk);
        #1;
        chk("wm_wcnt", wb_cnt, 1);
        chk("wm_mcnt", miss_cnt, 2);
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                pmem_resp = 1'b0;
                #1;
                chk("wb_pw", pmem_write, 1);
                chk("wb_pr", pmem_read, 0);
                chk("wb_addr", addr_sel, 1);
                chk("wb_way", way_sel, 1);
                chk("wb_beat", pmem_beat, b);
            end
            @(negedge clk);
            pmem_resp = 1'b1;
            #1;
            chk("wb_rbeat", pmem_beat, b);
            chk("wb_dw", data_write, 0);
            chk("wb_dc", dirty_clr, b == 3);
        end
        fill(1'b1);
        @(negedge clk);
        pmem_resp = 1'b0;
        hit_vec   = 2'b10;
        dirty_vec = 2'b00;
        #1;
        chk("wm_hit", mem_resp, 1);
        chk("wm_dw", data_write, 1);
        chk("wm_ds", dirty_set, 1);
        chk("wm_way", way_sel, 1);
        @(negedge clk);
        mem_write = 1'b0;
        hit_vec   = 2'b00;
        #1;
        chk("wm_hcnt", hit_cnt, 4);
        chk("wm_wcnt2", wb_cnt, 1);

        // Twenty read hits saturate the 4-bit counter
        mem_read = 1'b1;
        hit_vec  = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("sat_resp", mem_resp, 1);
            @(negedge clk);
        end
        mem_read = 1'b0;
        hit_vec  = 2'b00;
        #1;
        chk("sat_cnt", hit_cnt, 15);

        // Miss whose request drops after the first fill beat
        @(negedge clk);
        mem_read  = 1'b1;
        valid_vec = 2'b11;
        dirty_vec = 2'b00;
        lru_way   = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk("drop_b0", pmem_beat, 0);
        chk("drop_way", way_sel, 0);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            mem_read = 1'b0;
            #1;
            chk("drop_beat", pmem_beat, b);
            chk("drop_dw", data_write, 1);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk_idle("drop");
        chk("drop_mcnt", miss_cnt, 3);

        // Reset in the middle of a fill
        @(negedge clk);
        mem_read = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        #1;
        chk("mid_pr", pmem_read, 1);
        chk("mid_beat", pmem_beat, 2);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rbeat", pmem_beat, 0);
        chk("mid_hcnt", hit_cnt, 0);
        chk("mid_mcnt", miss_cnt, 0);
        chk("mid_wcnt", wb_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle("post_rst");
        @(negedge clk);
        mem_read = 1'b1;
        hit_vec  = 2'b01;
        #1;
        chk("post_hit", mem_resp, 1);
        chk("post_way", way_sel, 0);
        @(negedge clk);
        mem_read = 1'b0;
        hit_vec  = 2'b00;
        #1;
        chk("post_hcnt", hit_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
